// File: rtl/mult_pkg.sv
// mult_pkg: shared types for the shift-add multiplier bus master.
// Holds the controller state encoding and multiplier func codes.
package mult_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_M,
    LOAD_Q,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    READ_LO,
    READ_HI,
    OUT
  } state_t;

  localparam logic [1:0] FUNC_LD_M  = 2'b00;
  localparam logic [1:0] FUNC_LD_Q  = 2'b01;
  localparam logic [1:0] FUNC_RD_LO = 2'b10;
  localparam logic [1:0] FUNC_RD_HI = 2'b11;

endpackage

// File: rtl/mult_bus_master_start_pulser.sv
// start_pulser: holds the active-low start line for START_HOLD cycles.
// done marks the last low cycle so the caller can leave with the release.
module start_pulser #(
  parameter int START_HOLD = 4000
) (
  input  logic osc_clk,
  input  logic n_reset,
  input  logic go,
  output logic pb,
  output logic done
);

  localparam int CW = $clog2(START_HOLD + 1);

  logic [CW-1:0] cnt;

  assign done = ~pb & (cnt == '0);

  // pull pb low on go, release it after START_HOLD cycles
  always_ff @(posedge osc_clk or negedge n_reset) begin
    if (!n_reset) begin
      pb  <= 1'b1;
      cnt <= '0;
    end else if (go) begin
      pb  <= 1'b0;
      cnt <= CW'(START_HOLD - 1);
    end else if (!pb) begin
      if (cnt == '0) pb <= 1'b1;
      else           cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mult_bus_master.sv
// mult_bus_master: runs a full load/start/read transaction on the multiplier bus.
// Optional watchdog on the ready waits: define MULT_TIMEOUT_EN.
module mult_bus_master
  import mult_pkg::*;
#(
  parameter int n          = 8,
  parameter int START_HOLD = 4000,
  parameter int TIMEOUT    = 65535
) (
  input  logic           osc_clk,
  input  logic           n_reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [n-1:0]   in_m,
  input  logic [n-1:0]   in_q,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*n-1:0] res,
  output logic           err,
  output logic [1:0]     mul_func,
  output logic           mul_oe,
  output logic           mul_startPB,
  input  logic           mul_ready,
  output logic [n-1:0]   bus_dout,
  output logic           bus_drive,
  input  logic [n-1:0]   bus_din
);

  state_t       state;
  logic [n-1:0] q_r;
  logic         go;
  logic         done;
  logic         phase;
  logic         tmo;

  start_pulser #(
    .START_HOLD(START_HOLD)
  ) u_pulser (
    .osc_clk(osc_clk),
    .n_reset(n_reset),
    .go     (go),
    .pb     (mul_startPB),
    .done   (done)
  );

`ifdef MULT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt;
  logic          waiting;

  assign waiting = (state == WAIT_BUSY && mul_ready) ||
                   (state == WAIT_DONE && !mul_ready);
  assign tmo = waiting && (tcnt == TW'(TIMEOUT - 1));

  // watchdog: count while stuck in a wait state, latch err on expiry
  always_ff @(posedge osc_clk or negedge n_reset) begin
    if (!n_reset) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      tcnt <= waiting ? tcnt + 1'b1 : '0;
      if (tmo) err <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // transaction sequencer; func parks on read codes outside the loads
  always_ff @(posedge osc_clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      res       <= '0;
      mul_func  <= FUNC_RD_LO;
      mul_oe    <= 1'b0;
      bus_drive <= 1'b0;
      bus_dout  <= '0;
      q_r       <= '0;
      go        <= 1'b0;
      phase     <= 1'b0;
    end else begin
      go <= 1'b0;
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready  <= 1'b0;
            q_r       <= in_q;
            bus_dout  <= in_m;
            bus_drive <= 1'b1;
            mul_func  <= FUNC_LD_M;
            state     <= LOAD_M;
          end
        end
        LOAD_M: begin
          mul_func <= FUNC_LD_Q;
          bus_dout <= q_r;
          go       <= 1'b1;
          state    <= LOAD_Q;
        end
        LOAD_Q: begin
          mul_func  <= FUNC_RD_LO;
          bus_drive <= 1'b0;
          bus_dout  <= '0;
          state     <= START;
        end
        START: begin
          if (done) state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tmo) begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end else if (!mul_ready) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tmo) begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end else if (mul_ready) begin
            mul_oe <= 1'b1;
            state  <= READ_LO;
          end
        end
        READ_LO: begin
          phase <= ~phase;
          if (phase) begin
            res[n-1:0] <= bus_din;
            mul_func   <= FUNC_RD_HI;
            state      <= READ_HI;
          end
        end
        READ_HI: begin
          phase <= ~phase;
          if (phase) begin
            res[2*n-1:n] <= bus_din;
            mul_oe       <= 1'b0;
            mul_func     <= FUNC_RD_LO;
            res_valid    <= 1'b1;
            state        <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_bus_master.sv
// tb_mult_bus_master: directed bench with a multiplier model and scoreboard.
// Define MULT_TIMEOUT_EN to also exercise the watchdog path.
module tb_mult_bus_master;

  localparam int H   = 4000;
  localparam int TO  = 100;
  localparam int LAT = 3 + H + 6 + 8 + 4;

  logic        osc_clk   = 1'b0;
  logic        n_reset   = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [7:0]  in_m      = '0;
  logic [7:0]  in_q      = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res;
  logic        err;
  logic [1:0]  mul_func;
  logic        mul_oe;
  logic        mul_startPB;
  logic        mul_ready = 1'b1;
  logic [7:0]  bus_dout;
  logic        bus_drive;
  logic [7:0]  bus_din   = 8'hA5;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit hold_ready = 1'b0;

  mult_bus_master #(
    .n(8), .START_HOLD(H), .TIMEOUT(TO)
  ) dut (
    .osc_clk    (osc_clk),
    .n_reset    (n_reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_m       (in_m),
    .in_q       (in_q),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res        (res),
    .err        (err),
    .mul_func   (mul_func),
    .mul_oe     (mul_oe),
    .mul_startPB(mul_startPB),
    .mul_ready  (mul_ready),
    .bus_dout   (bus_dout),
    .bus_drive  (bus_drive),
    .bus_din    (bus_din)
  );

  always #5 osc_clk = ~osc_clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // multiplier model: latches loads, runs ready low 5..13 after release
  logic [7:0]  lm = '0;
  logic [7:0]  lq = '0;
  logic [15:0] prod;
  logic        pb_q = 1'b1;
  int          k = 0;
  bit          run = 1'b0;

  always @(negedge osc_clk) begin
    if (!n_reset) begin
      run = 1'b0; mul_ready = 1'b1; pb_q = 1'b1; bus_din = 8'hA5;
    end else begin
      if (mul_func == 2'b00) lm = bus_dout;
      if (mul_func == 2'b01) lq = bus_dout;
      if (!pb_q && mul_startPB && !hold_ready) begin run = 1'b1; k = 0; end
      pb_q = mul_startPB;
      if (run) begin
        if (k == 5) mul_ready = 1'b0;
        if (k == 13) begin mul_ready = 1'b1; run = 1'b0; end
        k++;
      end
      prod = lm * lq;
      if (!mul_oe) bus_din = 8'hA5;
      else bus_din = (mul_func == 2'b10) ? prod[7:0] : prod[15:8];
    end
  end

  // scoreboard and per-cycle protocol rules
  typedef struct {
    logic [7:0] m;
    logic [7:0] q;
    int t;
  } txn_t;

  txn_t        sb[$];
  int          n00 = 0, n01 = 0, npb = 0, last_drv = -10;
  logic [15:0] res_p = '0;
  bit          rv_p = 1'b0, hs_p = 1'b0;

  always @(negedge osc_clk) begin
    txn_t t;
    cyc++;
    if (!n_reset) begin
      sb.delete(); rv_p = 1'b0; hs_p = 1'b0;
      n00 = 0; n01 = 0; npb = 0;
    end else begin
      assert (!(bus_drive && mul_oe));
      assert (mul_func[1] || bus_drive);
      chk("no_contention", longint'(bus_drive & mul_oe), 0);
      chk("func_park", longint'(!mul_func[1] && !bus_drive), 0);
      if (mul_oe) chk("drive_gap", longint'(cyc - last_drv > 1), 1);
      if (bus_drive) last_drv = cyc;
      if (mul_func == 2'b00) begin
        n00++;
        if (sb.size() > 0) chk("wr_m", bus_dout, sb[0].m);
      end
      if (mul_func == 2'b01) begin
        n01++;
        if (sb.size() > 0) chk("wr_q", bus_dout, sb[0].q);
      end
      if (!mul_startPB) npb++;
      if (hs_p) begin
        chk("idle_after_hs", in_ready, 1);
        chk("rv_one_cycle", res_valid, 0);
      end else if (rv_p && res_valid) begin
        chk("res_hold", res, res_p);
        chk("busy_in_ready", in_ready, 0);
      end
      if (res_valid && !rv_p) begin
        if (sb.size() == 0) chk("spurious_res", 1, 0);
        else begin
          t = sb.pop_front();
          chk("product", res, longint'(t.m) * longint'(t.q));
          chk("latency", cyc - t.t, LAT);
          chk("n_ld_m", n00, 1);
          chk("n_ld_q", n01, 1);
          chk("pb_low", npb, H);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{m: in_m, q: in_q, t: cyc});
        n00 = 0; n01 = 0; npb = 0;
      end
      hs_p = res_valid && res_ready;
      rv_p = res_valid;
      res_p = res;
    end
  end

  task automatic send(input logic [7:0] m, input logic [7:0] q);
    int t = 0;
    @(posedge osc_clk); #1;
    in_m = m; in_q = q; in_valid = 1'b1;
    while (1) begin
      @(negedge osc_clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin chk("accept_timeout", 0, 1); break; end
    end
    @(posedge osc_clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_res(input logic [15:0] exp, input string name);
    int t = 0;
    while (!res_valid && t < LAT + 100) begin
      @(negedge osc_clk); t++;
    end
    if (!res_valid) chk({name, "_timeout"}, 0, 1);
    else chk(name, res, exp);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge osc_clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_err", err, 0);
    chk("rst_func", mul_func, 2);
    chk("rst_oe", mul_oe, 0);
    chk("rst_pb", mul_startPB, 1);
    chk("rst_drive", bus_drive, 0);
    chk("rst_dout", bus_dout, 0);
    @(posedge osc_clk); #2 n_reset = 1'b1;

    send(8'd13, 8'd11);
    wait_res(16'h008F, "basic");
    send(8'd255, 8'd255);
    wait_res(16'hFE01, "max");

    @(posedge osc_clk); #1 res_ready = 1'b0;
    send(8'd200, 8'd3);
    wait_res(16'h0258, "bp");
    repeat (20) @(negedge osc_clk);
    chk("bp_still_valid", res_valid, 1);
    chk("bp_res", res, 16'h0258);
    @(posedge osc_clk); #1;
    res_ready = 1'b1; in_m = 8'd17; in_q = 8'd19; in_valid = 1'b1;
    @(negedge osc_clk);
    chk("bp_hs_in_ready", in_ready, 0);
    @(negedge osc_clk);
    chk("b2b_accept", in_ready, 1);
    @(posedge osc_clk); #1 in_valid = 1'b0;
    wait_res(16'h0143, "b2b");

    send(8'd9, 8'd9);
    t = 0;
    while (mul_ready && t < LAT + 100) begin @(negedge osc_clk); t++; end
    chk("reached_wait_done", mul_ready, 0);
    repeat (3) @(negedge osc_clk);
    #2 n_reset = 1'b0;
    #1;
    chk("mid_rst_pb", mul_startPB, 1);
    chk("mid_rst_drive", bus_drive, 0);
    chk("mid_rst_oe", mul_oe, 0);
    chk("mid_rst_rv", res_valid, 0);
    chk("mid_rst_func", mul_func, 2);
    repeat (2) @(posedge osc_clk);
    #2 n_reset = 1'b1;
    send(8'd3, 8'd7);
    wait_res(16'h0015, "after_reset");

`ifdef MULT_TIMEOUT_EN
    @(posedge osc_clk); #1 hold_ready = 1'b1;
    send(8'd5, 8'd5);
    t = 0;
    while (!mul_startPB || pb_q == 1'b0 && t == 0) begin
      @(negedge osc_clk); t++;
      if (t > H + 50) break;
    end
    t = 0;
    while (!err && t < TO + 50) begin
      @(negedge osc_clk); t++;
      chk("to_no_res", res_valid, 0);
    end
    chk("to_err", err, 1);
    chk("to_cycles", t, TO);
    @(negedge osc_clk);
    chk("to_idle", in_ready, 1);
    chk("to_err_sticky", err, 1);
`else
    chk("err_tied", err, 0);
`endif

    repeat (3) @(negedge osc_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
